// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: command front-end for the simple ALU.
// Queues {a, b, op} commands in a DEPTH-entry FIFO (valid/ready), issues one
// command at a time to the ALU, waits RESULT_LAT edges after the edge that
// samples alu_start, captures alu_c and returns it on a valid/ready response.
// Optional build macro: ALU_DIV0_CHECK_EN (DIV/MOD by zero answered with
// rsp_err=1, rsp_data=0 and never issued to the ALU).
module alu_cmd_sequencer #(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned RESULT_LAT = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_a,
   input  logic [31:0] cmd_b,
   input  logic [2:0]  cmd_op,
   output logic        alu_start,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [2:0]  alu_mode,
   input  logic [31:0] alu_c,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic        busy
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
   typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_ACC, OP_MAC} op_e;

   logic [31:0]   r_fifo_a  [DEPTH];
   logic [31:0]   r_fifo_b  [DEPTH];
   logic [2:0]    r_fifo_op [DEPTH];
   logic [AW:0]   r_wptr;
   logic [AW:0]   r_rptr;

   state_e        r_state;
   state_e        w_next;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_alu_a;
   logic [31:0]   r_alu_b;
   logic [2:0]    r_alu_mode;
   logic          r_rsp_valid;
   logic [31:0]   r_rsp_data;
   logic          r_rsp_err;

   logic          w_empty;
   logic          w_full;
   logic          w_push;
   logic          w_pop;
   logic          w_issue;
   logic          w_div0;
   logic [31:0]   w_head_a;
   logic [31:0]   w_head_b;
   logic [2:0]    w_head_op;

   assign w_empty   = (r_wptr == r_rptr);
   assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_push    = cmd_valid && !w_full;
   assign w_pop     = (r_state == S_IDLE) && !w_empty;
   assign w_head_a  = r_fifo_a[r_rptr[AW-1:0]];
   assign w_head_b  = r_fifo_b[r_rptr[AW-1:0]];
   assign w_head_op = r_fifo_op[r_rptr[AW-1:0]];

`ifdef ALU_DIV0_CHECK_EN
   assign w_div0 = ((w_head_op == OP_DIV) || (w_head_op == OP_MOD)) && (w_head_b == '0);
`else
   assign w_div0 = 1'b0;
`endif

   assign w_issue = w_pop && !w_div0;

   // FIFO storage write (no reset needed; pointers define validity)
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_fifo_a[r_wptr[AW-1:0]]  <= cmd_a;
         r_fifo_b[r_wptr[AW-1:0]]  <= cmd_b;
         r_fifo_op[r_wptr[AW-1:0]] <= cmd_op;
      end
   end

   // FIFO pointers with extra wrap bit
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
         if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
      end
   end

   // FSM state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // FSM next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (!w_empty) w_next = w_div0 ? S_RESP : S_WAIT;
         S_WAIT:  if (r_cnt == '0) w_next = S_RESP;
         S_RESP:  if (r_rsp_valid && rsp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Issue registers, latency counter and response capture
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt       <= '0;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_mode  <= OP_ADD;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_issue) begin
                  r_alu_a    <= w_head_a;
                  r_alu_b    <= w_head_b;
                  r_alu_mode <= w_head_op;
                  r_cnt      <= CW'(RESULT_LAT - 1);
               end else if (w_pop) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_data  <= '0;
                  r_rsp_err   <= 1'b1;
               end
            end
            S_WAIT: begin
               if (r_cnt == '0) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_data  <= alu_c;
                  r_rsp_err   <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_RESP: begin
               if (r_rsp_valid && rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_rsp_err   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs. The FIFO head is presented on alu_a/b/mode during the issue
   // cycle so the ALU samples operands together with alu_start; the issue
   // registers then hold them steady until the response handshake.
   always_comb begin
      cmd_ready = !w_full;
      alu_start = w_issue;
      alu_a     = w_issue ? w_head_a  : r_alu_a;
      alu_b     = w_issue ? w_head_b  : r_alu_b;
      alu_mode  = w_issue ? w_head_op : r_alu_mode;
      rsp_valid = r_rsp_valid;
      rsp_data  = r_rsp_data;
      rsp_err   = r_rsp_err;
      busy      = (r_state != S_IDLE) || !w_empty;
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural ALU whose
// result is only valid on alu_c exactly RESULT_LAT edges after alu_start.
module tb_alu_cmd_sequencer;

   localparam int unsigned DEPTH      = 4;
   localparam int unsigned RESULT_LAT = 2;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_a = '0;
   logic [31:0] cmd_b = '0;
   logic [2:0]  cmd_op = '0;
   logic        alu_start;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [2:0]  alu_mode;
   logic [31:0] alu_c = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        busy;

   int unsigned n_pass = 0;
   int unsigned n_total = 0;
   int unsigned cyc = 0;
   int unsigned n_start = 0;
   int unsigned last_start = 0;
   int unsigned prev_start = 0;
   logic [31:0] exp_q[$];
   logic        exp_e_q[$];

   logic [31:0] m_pend = '0;
   int unsigned m_due = 0;
   bit          m_have = 1'b0;

   alu_cmd_sequencer #(.DEPTH(DEPTH), .RESULT_LAT(RESULT_LAT)) dut (
      .clock(clock), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
      .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode),
      .alu_c(alu_c),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_err(rsp_err), .busy(busy)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a * b;
         3'd3:    return (b == 0) ? 32'd0 : a / b;
         3'd4:    return (b == 0) ? 32'd0 : a % b;
         default: return a + b;
      endcase
   endfunction

   function automatic logic exp_err(input logic [31:0] b, input logic [2:0] op);
`ifdef ALU_DIV0_CHECK_EN
      return ((op == 3'd3) || (op == 3'd4)) && (b == 0);
`else
      return 1'b0;
`endif
   endfunction

   // Cycle counter and alu_start monitor
   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (reset_n && alu_start) begin
         n_start    <= n_start + 1;
         prev_start <= last_start;
         last_start <= cyc;
      end
   end

   // ALU model: result visible on alu_c only for the edge S+RESULT_LAT
   always @(posedge clock) begin
      if (alu_start) begin
         m_pend <= alu_f(alu_a, alu_b, alu_mode);
         m_due  <= cyc + RESULT_LAT - 1;
         m_have <= 1'b1;
      end
      if (m_have && cyc == m_due) begin
         alu_c  <= m_pend;
         m_have <= 1'b0;
      end else begin
         alu_c <= 32'hBAD0_0000 | (cyc & 32'h0000_FFFF);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push_cmd(input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op, output int unsigned pcyc);
      int unsigned k;
      k = 0;
      @(negedge clock);
      cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
      while (cmd_ready !== 1'b1 && k < 200) begin @(negedge clock); k++; end
      if (cmd_ready !== 1'b1) begin
         n_total++;
         $display("FAIL push_timeout cmd_ready got %b want 1", cmd_ready);
      end
      @(posedge clock); #1;
      pcyc = cyc;
      cmd_valid = 1'b0;
      exp_q.push_back(exp_err(b, op) ? 32'd0 : alu_f(a, b, op));
      exp_e_q.push_back(exp_err(b, op));
   endtask

   task automatic get_rsp(input logic hold, output logic [31:0] d, output logic e,
                          output int unsigned seen);
      int unsigned k;
      k = 0;
      @(negedge clock);
      while (rsp_valid !== 1'b1 && k < 100) begin @(negedge clock); k++; end
      if (rsp_valid !== 1'b1) begin
         n_total++;
         $display("FAIL rsp_timeout rsp_valid got %b want 1", rsp_valid);
      end
      d = rsp_data; e = rsp_err; seen = cyc;
      rsp_ready = 1'b1;
      @(posedge clock); #1;
      rsp_ready = hold;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
      repeat (3) @(negedge clock);
      n_total++;
      if ({cmd_ready, alu_start, rsp_valid, rsp_err, busy} !== 5'b10000)
         $display("FAIL reset_flags got %b want 10000", {cmd_ready, alu_start, rsp_valid, rsp_err, busy});
      else n_pass++;
      n_total++;
      if ({alu_a, alu_b, alu_mode, rsp_data} !== 99'd0)
         $display("FAIL reset_data got a=%h b=%h mode=%0d rsp=%h want all 0", alu_a, alu_b, alu_mode, rsp_data);
      else n_pass++;
      reset_n = 1'b1;
      @(negedge clock);
      n_total++;
      if ({cmd_ready, alu_start, rsp_valid, busy} !== 4'b1000)
         $display("FAIL post_reset_flags got %b want 1000", {cmd_ready, alu_start, rsp_valid, busy});
      else n_pass++;
   endtask

   task automatic test_single_add();
      int unsigned pc, seen;
      logic [31:0] d, x;
      logic e;
      rsp_ready = 1'b1;
      push_cmd(32'd5, 32'd7, 3'd0, pc);
      @(negedge clock);
      n_total++;
      if (alu_start !== 1'b1 || alu_a !== 32'd5 || alu_b !== 32'd7 || alu_mode !== 3'd0)
         $display("FAIL add_issue got start=%b a=%0d b=%0d mode=%0d want 1 5 7 0", alu_start, alu_a, alu_b, alu_mode);
      else n_pass++;
      @(negedge clock);
      n_total++;
      if (alu_start !== 1'b0) $display("FAIL add_start_pulse got %b want 0", alu_start);
      else n_pass++;
      get_rsp(1'b1, d, e, seen);
      x = exp_q.pop_front(); void'(exp_e_q.pop_front());
      n_total++;
      if (d !== x || e !== 1'b0) $display("FAIL add_data got %0d err=%b want %0d err=0", d, e, x);
      else n_pass++;
      n_total++;
      if (seen - pc !== RESULT_LAT + 1)
         $display("FAIL add_latency got %0d want %0d", seen - pc, RESULT_LAT + 1);
      else n_pass++;
      rsp_ready = 1'b0;
   endtask

   task automatic test_back_pressure();
      int unsigned pc, seen, s0, k;
      logic [31:0] d, x;
      logic e;
      rsp_ready = 1'b0;
      s0 = n_start;
      push_cmd(32'd3, 32'd4, 3'd2, pc);
      k = 0;
      @(negedge clock);
      while (rsp_valid !== 1'b1 && k < 50) begin @(negedge clock); k++; end
      x = exp_q[0];
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         n_total++;
         if (rsp_valid !== 1'b1 || rsp_data !== x || alu_mode !== 3'd2 || alu_a !== 32'd3 || alu_b !== 32'd4)
            $display("FAIL bp_hold cycle %0d got valid=%b data=%0d mode=%0d a=%0d b=%0d want 1 %0d 2 3 4",
                     i, rsp_valid, rsp_data, alu_mode, alu_a, alu_b, x);
         else n_pass++;
      end
      n_total++;
      if (n_start - s0 !== 1) $display("FAIL bp_start_count got %0d want 1", n_start - s0);
      else n_pass++;
      get_rsp(1'b0, d, e, seen);
      x = exp_q.pop_front(); void'(exp_e_q.pop_front());
      n_total++;
      if (d !== x) $display("FAIL bp_data got %0d want %0d", d, x);
      else n_pass++;
      @(negedge clock);
      n_total++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) $display("FAIL bp_idle got busy=%b valid=%b want 0 0", busy, rsp_valid);
      else n_pass++;
   endtask

   task automatic test_fifo_full();
      logic [31:0] ta[5] = '{32'd6, 32'd10, 32'd20, 32'd17, 32'hFFFF_FFFF};
      logic [31:0] tb[5] = '{32'd7, 32'd3, 32'd4, 32'd5, 32'd1};
      logic [2:0]  to[5] = '{3'd2, 3'd1, 3'd3, 3'd4, 3'd0};
      logic [31:0] want[5] = '{32'd42, 32'd7, 32'd5, 32'd2, 32'd0};
      int unsigned pc, seen, s0;
      logic [31:0] d, x;
      logic e, xe;
      rsp_ready = 1'b0;
      s0 = n_start;
      for (int i = 0; i < 5; i++) push_cmd(ta[i], tb[i], to[i], pc);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         n_total++;
         if (cmd_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL full_ready cycle %0d got ready=%b busy=%b want 0 1", i, cmd_ready, busy);
         else n_pass++;
      end
      for (int i = 0; i < 5; i++) begin
         get_rsp(1'b0, d, e, seen);
         x = exp_q.pop_front(); xe = exp_e_q.pop_front();
         n_total++;
         if (d !== x || d !== want[i] || e !== xe)
            $display("FAIL full_order rsp %0d got %h err=%b want %h err=%b", i, d, e, want[i], xe);
         else n_pass++;
      end
      @(negedge clock);
      n_total++;
      if (n_start - s0 !== 5 || busy !== 1'b0)
         $display("FAIL full_drain got starts=%0d busy=%b want 5 0", n_start - s0, busy);
      else n_pass++;
   endtask

   task automatic test_simul_push_pop();
      int unsigned pc, seen, s0, k;
      logic [31:0] d, x;
      logic e;
      bit extra;
      rsp_ready = 1'b0;
      s0 = n_start;
      push_cmd(32'd100, 32'd23, 3'd0, pc);
      k = 0;
      @(negedge clock);
      while (rsp_valid !== 1'b1 && k < 50) begin @(negedge clock); k++; end
      push_cmd(32'd50, 32'd8, 3'd1, pc);
      @(negedge clock);
      x = exp_q.pop_front(); void'(exp_e_q.pop_front());
      n_total++;
      if (rsp_valid !== 1'b1 || rsp_data !== x) $display("FAIL spp_first got valid=%b %0d want 1 %0d", rsp_valid, rsp_data, x);
      else n_pass++;
      rsp_ready = 1'b1;
      @(posedge clock); #1;
      rsp_ready = 1'b0;
      @(negedge clock);
      n_total++;
      if (alu_start !== 1'b1 || cmd_ready !== 1'b1)
         $display("FAIL spp_pop_edge got start=%b ready=%b want 1 1", alu_start, cmd_ready);
      else n_pass++;
      cmd_valid = 1'b1; cmd_a = 32'd7; cmd_b = 32'd8; cmd_op = 3'd0;
      exp_q.push_back(32'd15); exp_e_q.push_back(1'b0);
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      @(negedge clock);
      n_total++;
      if (alu_start !== 1'b0 || busy !== 1'b1) $display("FAIL spp_after got start=%b busy=%b want 0 1", alu_start, busy);
      else n_pass++;
      for (int i = 0; i < 2; i++) begin
         get_rsp(1'b0, d, e, seen);
         x = exp_q.pop_front(); void'(exp_e_q.pop_front());
         n_total++;
         if (d !== x) $display("FAIL spp_data rsp %0d got %0d want %0d", i, d, x);
         else n_pass++;
      end
      extra = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         if (rsp_valid === 1'b1) extra = 1'b1;
      end
      n_total++;
      if (extra || n_start - s0 !== 3 || busy !== 1'b0)
         $display("FAIL spp_no_dup got extra=%b starts=%0d busy=%b want 0 3 0", extra, n_start - s0, busy);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int unsigned pc, seen;
      logic [31:0] d, x;
      logic e;
      rsp_ready = 1'b1;
      push_cmd(32'd1, 32'd1, 3'd0, pc);
      push_cmd(32'd2, 32'd9, 3'd2, pc);
      for (int i = 0; i < 2; i++) begin
         get_rsp(1'b1, d, e, seen);
         x = exp_q.pop_front(); void'(exp_e_q.pop_front());
         n_total++;
         if (d !== x) $display("FAIL b2b_data rsp %0d got %0d want %0d", i, d, x);
         else n_pass++;
      end
      n_total++;
      if (last_start - prev_start !== RESULT_LAT + 2)
         $display("FAIL b2b_spacing got %0d want %0d", last_start - prev_start, RESULT_LAT + 2);
      else n_pass++;
      rsp_ready = 1'b0;
   endtask

   task automatic test_div0();
      int unsigned pc, seen, s0, want_starts;
      logic [31:0] d, x;
      logic e, xe;
      rsp_ready = 1'b1;
      s0 = n_start;
      push_cmd(32'd9, 32'd0, 3'd3, pc);
      get_rsp(1'b1, d, e, seen);
      x = exp_q.pop_front(); xe = exp_e_q.pop_front();
`ifdef ALU_DIV0_CHECK_EN
      want_starts = 0;
`else
      want_starts = 1;
`endif
      n_total++;
      if (d !== x || e !== xe) $display("FAIL div0_rsp got %0d err=%b want %0d err=%b", d, e, x, xe);
      else n_pass++;
      n_total++;
      if (n_start - s0 !== want_starts) $display("FAIL div0_start got %0d want %0d", n_start - s0, want_starts);
      else n_pass++;
      push_cmd(32'd9, 32'd3, 3'd3, pc);
      get_rsp(1'b1, d, e, seen);
      x = exp_q.pop_front(); xe = exp_e_q.pop_front();
      n_total++;
      if (d !== x || e !== xe) $display("FAIL div_ok got %0d err=%b want %0d err=%b", d, e, x, xe);
      else n_pass++;
      rsp_ready = 1'b0;
   endtask

   task automatic test_mid_reset();
      int unsigned pc, s0;
      bit seen_valid;
      rsp_ready = 1'b1;
      push_cmd(32'd1, 32'd2, 3'd0, pc);
      push_cmd(32'd9, 32'd1, 3'd1, pc);
      s0 = n_start;
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      n_total++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
         $display("FAIL midrst_async got busy=%b valid=%b ready=%b want 0 0 1", busy, rsp_valid, cmd_ready);
      else n_pass++;
      exp_q.delete(); exp_e_q.delete();
      @(negedge clock);
      reset_n = 1'b1;
      seen_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         if (rsp_valid === 1'b1) seen_valid = 1'b1;
      end
      n_total++;
      if (seen_valid || busy !== 1'b0 || n_start !== s0)
         $display("FAIL midrst_abort got valid_seen=%b busy=%b new_starts=%0d want 0 0 0", seen_valid, busy, n_start - s0);
      else n_pass++;
      rsp_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_back_pressure();
      test_fifo_full();
      test_simul_push_pop();
      test_back_to_back();
      test_div0();
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Command front-end for the simple ALU.
- Buffers operand/opcode commands in a small FIFO using a valid/ready handshake.
- Issues one command at a time to the ALU (start, a, b, mode_select) and waits a fixed number of cycles for the result.
- Captures the ALU output c and returns it on a valid/ready response channel.
- Sits directly upstream of the ALU and also consumes its result.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, >=2)
RESULT_LAT, 2, cycles from the clock edge that samples start=1 to the edge at which alu_c holds the result

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept a command (not full)
cmd_a  in  32  operand a
cmd_b  in  32  operand b
cmd_op  in  3  opcode (tb_pkg opcode: ADD, SUB, MUL, DIV, MOD, ACC, MAC)
alu_start  out  1  to ALU start
alu_a  out  32  to ALU a
alu_b  out  32  to ALU b
alu_mode  out  3  to ALU mode_select
alu_c  in  32  from ALU c
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_data  out  32  captured result
rsp_err  out  1  error flag (optional feature only; tied 0 otherwise)
busy  out  1  FSM not IDLE or FIFO not empty

Behaviour:
- Reset values: cmd_ready=1, alu_start=0, alu_a=0, alu_b=0, alu_mode=ADD, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0. The FIFO is emptied and the FSM enters IDLE.
- Reset asserted mid-operation aborts the in-flight command and discards all queued commands. No response is produced for them.
- FIFO push: occurs when cmd_valid && cmd_ready. cmd_ready = !full, registered-state based, with no combinational path from cmd_valid.
- Full/empty detection: read/write pointers carry one extra wrap bit. A push and a pop in the same cycle are legal when the FIFO is not empty. When full, a push is blocked even if a pop occurs in that cycle.
- Push-to-pop latency: a command pushed at edge N can be popped at the earliest at edge N+1.
- FSM states:
  - IDLE: if the FIFO is not empty, pop the head, load alu_a, alu_b and alu_mode registers, assert alu_start for exactly one cycle, and go to WAIT.
  - WAIT: a counter counts RESULT_LAT edges after the edge that sampled alu_start=1. At terminal count, rsp_data <= alu_c, rsp_valid <= 1, and the FSM goes to RESP.
  - RESP: hold rsp_valid/rsp_data until rsp_valid && rsp_ready. Then clear rsp_valid and return to IDLE. The next issue starts no earlier than the cycle after the handshake.
- alu_a, alu_b and alu_mode stay stable from issue until the RESP handshake. The ALU recomputes every cycle, so alu_mode must not change before capture.
- ACC/MAC: the result is the ALU's accumulator value sampled at exactly RESULT_LAT. The sequencer does not compensate for extra accumulation.
- Arithmetic: none is performed here. All data is 32-bit pass-through.
- Throughput: at most one command in flight. Minimum spacing is RESULT_LAT+2 cycles per command when rsp_ready is held at 1.
- busy is combinational from state and FIFO count.

Optional Feature:
Macro ALU_DIV0_CHECK_EN.
- Defined: in IDLE, a popped command with op DIV or MOD and b==0 is not issued; alu_start stays 0. The FSM goes directly to RESP with rsp_data=0 and rsp_err=1. All other commands give rsp_err=0.
- Undefined: every command is issued unchanged and rsp_err is tied to 0.

Test Plan:
- Reset: after release, cmd_ready=1, rsp_valid=0, busy=0, alu_start=0. Assert reset_n=0 during WAIT, then release: no rsp_valid appears and busy=0.
- Single ADD: a=5, b=7, rsp_ready=1. alu_start pulses 1 cycle, rsp_valid rises RESULT_LAT+1 cycles after the push edge, rsp_data=12.
- Back-pressure: MUL a=3, b=4 with rsp_ready=0 for 10 cycles. rsp_valid and rsp_data=12 hold steady, and there is no second alu_start until the handshake.
- FIFO full: push 5 commands back-to-back with rsp_ready=0 and DEPTH=4. After the FSM pops one, up to 4 more are accepted and cmd_ready drops to 0. Responses come out in order: SUB 10-3=7, DIV 20/4=5, MOD 17/5=2, ADD 0xFFFFFFFF+1=0 (wrap).
- Simultaneous push/pop: push on the same edge that IDLE pops with the FIFO at count 1. Count stays 1 and no command is lost or duplicated.
- ALU_DIV0_CHECK_EN: DIV a=9, b=0 gives rsp_err=1, rsp_data=0, and no alu_start. Without the macro, alu_start pulses and rsp_err=0.
